byte_stream_sink: RTL and testbench
===================================

Name: byte_stream_sink

Overview:
- Receive-side endpoint for the 8-bit data/enable strobe stream that upstream datapath blocks drive.
- Captures each strobed byte into a circular FIFO and presents it to a downstream consumer through a show-ahead pop interface.
- Flags dropped bytes with a sticky overflow bit; the consumer clears the bit.
- Sits between a byte producer and any slower reader, such as a register-bus bridge or a packer.

Parameters:
- DEPTH, 8, number of FIFO entries; must be a power of 2 and >= 2.
- DATA_W, 8, byte width of data_in and rd_data.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- data_in  input  DATA_W  byte from the producer; sampled only when enable=1.
- enable  input  1  write strobe from the producer; one byte per cycle high.
- rd_en  input  1  pop request from the consumer.
- rd_data  output  DATA_W  head-of-FIFO byte; valid when rd_valid=1.
- rd_valid  output  1  FIFO non-empty (equals ~empty).
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.
- level  output  $clog2(DEPTH)+1  number of stored bytes.
- overflow  output  1  sticky; set when a strobed byte is dropped.
- ovf_clr  input  1  synchronous clear of overflow.

Behaviour:
- Interface: one clock, clk; asynchronous active-low reset, rst_n.
- Reset (rst_n=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, level=0, overflow=0.
  - empty=1, full=0, rd_valid=0, rd_data=0.
  - Storage array is not reset.
- Pointers: log2(DEPTH) bits wide; they wrap naturally from DEPTH-1 to 0. level is a separate counter.
- Push: occurs when enable=1 and full=0 (full as registered at the start of the cycle). mem[wr_ptr]<=data_in, wr_ptr+1.
- Pop: occurs when rd_en=1 and empty=0. rd_ptr+1. rd_en while empty is ignored and causes no error.
- rd_data is combinational from mem[rd_ptr]. It is 0 while empty, so it never shows stale data.
- Latency: a byte pushed in cycle N is visible on rd_data/rd_valid in cycle N+1.
- No fall-through while empty.
- Simultaneous push and pop:
  - Non-full, non-empty: both take effect and level is unchanged.
  - Empty: only the push takes effect.
  - Full: the push is dropped, because full is evaluated before the pop. The pop takes effect and level becomes DEPTH-1.
- Overflow: enable=1 while full=1 drops the byte and sets overflow on the next edge. If ovf_clr and an overflow event occur in the same cycle, set wins.
- level update: +1 on push only, -1 on pop only, otherwise unchanged. It never exceeds DEPTH and never underflows.
- full and empty are registered, derived from the next level value, and change on the same edge as level.
- Reset mid-operation: all contents are discarded immediately. The first push after reset release lands in mem[0].

Optional Feature:
- Macro: SINK_PARITY_EN.
- Defined:
  - Adds input data_par (1 bit, even parity over data_in) and output par_err (1 bit, sticky).
  - A strobed byte whose XOR of data_in and data_par is 1 is not written.
  - On such a byte, par_err is set on the next edge.
  - par_err is cleared by ovf_clr, and set wins in the same cycle. Reset value is 0.
  - A parity-bad byte arriving while full sets both par_err and overflow.
- Undefined: no data_par or par_err ports; every strobed byte is subject only to the full check.

Test Plan:
- Reset then idle → empty=1, full=0, level=0, rd_valid=0, rd_data=0, overflow=0.
- Push 0x11, 0x22, 0x33 on consecutive cycles, then rd_en for 3 cycles → rd_data sequence 0x11, 0x22, 0x33; level 3→0; empty=1 after the last pop.
- Fill all 8 entries with 0xA0..0xA7, then push 0xFF → full=1, overflow=1, level=8; draining yields 0xA0..0xA7 with 0xFF absent.
- When full, assert enable=1 (data 0x55) and rd_en=1 in the same cycle → 0x55 dropped, overflow=1, level=7, head advances to the second byte.
- Pipe 20 bytes 0x00..0x13 with a pop every cycle after the first push → pointers wrap twice, output order is exact, level stays ≤1, overflow=0.
- Assert rst_n=0 asynchronously mid-cycle with level=5 → level=0 and empty=1 immediately. After release, push 0x7E → rd_data=0x7E. With SINK_PARITY_EN, push 0x03 with data_par=1 → byte dropped, par_err=1.

Source files
------------

// File: rtl/byte_stream_sink_if.sv
// Byte-stream sink bundle: producer strobe, consumer pop port and status flags.
// Optional parity pair is present only when SINK_PARITY_EN is defined.
interface byte_stream_sink_if #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0]       data_in;
    logic                    enable;
    logic                    rd_en;
    logic                    ovf_clr;
    logic [DATA_W-1:0]       rd_data;
    logic                    rd_valid;
    logic                    full;
    logic                    empty;
    logic [$clog2(DEPTH):0]  level;
    logic                    overflow;
`ifdef SINK_PARITY_EN
    logic                    data_par;
    logic                    par_err;
`endif

    modport master (
        output data_in, enable, rd_en, ovf_clr,
`ifdef SINK_PARITY_EN
        output data_par,
        input  par_err,
`endif
        input  rd_data, rd_valid, full, empty, level, overflow
    );

    modport slave (
        input  data_in, enable, rd_en, ovf_clr,
`ifdef SINK_PARITY_EN
        input  data_par,
        output par_err,
`endif
        output rd_data, rd_valid, full, empty, level, overflow
    );
endinterface

// File: rtl/byte_stream_sink.sv
// Circular show-ahead FIFO that captures strobed bytes and flags drops with a sticky overflow.
// Optional even-parity filtering of incoming bytes is enabled by the SINK_PARITY_EN macro.
module byte_stream_sink #(
    parameter int DEPTH  = 8,   // power of 2, >= 2
    parameter int DATA_W = 8
) (
    input logic               clk,
    input logic               rst_n,
    byte_stream_sink_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             overflow_q, overflow_d;
    logic             par_err_q, par_err_d;
    logic             byte_ok;
    logic             push;
    logic             pop;

    always_comb begin
        byte_ok   = 1'b1;
        par_err_d = 1'b0;
`ifdef SINK_PARITY_EN
        byte_ok   = ~(^bus.data_in ^ bus.data_par);
        if (bus.enable && !byte_ok)
            par_err_d = 1'b1;
        else if (bus.ovf_clr)
            par_err_d = 1'b0;
        else
            par_err_d = par_err_q;
`endif
        // full is the registered flag, so a pop in the same cycle cannot make room for the push
        push = bus.enable && !full_q && byte_ok;
        pop  = bus.rd_en && !empty_q;

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        full_d  = (level_d == LVL_W'(DEPTH));
        empty_d = (level_d == '0);

        if (bus.enable && full_q)
            overflow_d = 1'b1;
        else if (bus.ovf_clr)
            overflow_d = 1'b0;
        else
            overflow_d = overflow_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            par_err_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            par_err_q  <= par_err_d;
        end
    end

    // Storage is deliberately left unreset; empty gating keeps stale bytes off rd_data.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= bus.data_in;
    end

    assign bus.rd_data  = empty_q ? '0 : mem_q[rd_ptr_q];
    assign bus.rd_valid = ~empty_q;
    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.level    = level_q;
    assign bus.overflow = overflow_q;
`ifdef SINK_PARITY_EN
    assign bus.par_err  = par_err_q;
`endif
endmodule

// File: tb/tb_byte_stream_sink.sv
// Scoreboard bench for byte_stream_sink: accepted bytes are queued at stimulus time,
// a negedge monitor pops and compares every byte the DUT hands out.
module tb_byte_stream_sink;
    localparam int DEPTH  = 8;
    localparam int DATA_W = 8;

    logic clk;
    logic rst_n;

    byte_stream_sink_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

    byte_stream_sink #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [DATA_W-1:0] exp_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a pop happens on the coming edge whenever rd_en and rd_valid are both high.
    always @(negedge clk) begin
        if (rst_n && bus.rd_en && bus.rd_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL pop_unexpected: got 0x%0h, expected no data at %0t", bus.rd_data, $time);
            end else begin
                check("pop_data", int'(bus.rd_data), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [DATA_W-1:0] d, input logic rd);
        bus.enable  = en;
        bus.data_in = d;
        bus.rd_en   = rd;
`ifdef SINK_PARITY_EN
        bus.data_par = ^d;
`endif
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0);
        bus.ovf_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Reset state
        check("rst_empty",    int'(bus.empty),    1);
        check("rst_full",     int'(bus.full),     0);
        check("rst_level",    int'(bus.level),    0);
        check("rst_rd_valid", int'(bus.rd_valid), 0);
        check("rst_rd_data",  int'(bus.rd_data),  0);
        check("rst_overflow", int'(bus.overflow), 0);

        // rd_en while empty is ignored
        drive(1'b0, '0, 1'b1);
        step();
        idle();
        check("rd_empty_level", int'(bus.level), 0);
        check("rd_empty_flag",  int'(bus.empty), 1);

        // Three pushes then three pops
        drive(1'b1, 8'h11, 1'b0); exp_q.push_back(8'h11); step();
        check("latency_valid", int'(bus.rd_valid), 1);
        check("latency_data",  int'(bus.rd_data),  8'h11);
        drive(1'b1, 8'h22, 1'b0); exp_q.push_back(8'h22); step();
        drive(1'b1, 8'h33, 1'b0); exp_q.push_back(8'h33); step();
        idle();
        check("three_level", int'(bus.level), 3);
        drive(1'b0, '0, 1'b1);
        repeat (3) step();
        idle();
        check("three_drained_level", int'(bus.level), 0);
        check("three_drained_empty", int'(bus.empty), 1);
        check("three_drained_data",  int'(bus.rd_data), 0);

        // Fill, overflow by one, drain
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 8'hA0 + 8'(i), 1'b0);
            exp_q.push_back(8'hA0 + 8'(i));
            step();
        end
        drive(1'b1, 8'hFF, 1'b0);
        step();
        idle();
        check("fill_full",     int'(bus.full),     1);
        check("fill_overflow", int'(bus.overflow), 1);
        check("fill_level",    int'(bus.level),    8);
        drive(1'b0, '0, 1'b1);
        repeat (DEPTH) step();
        idle();
        check("fill_drained_empty", int'(bus.empty), 1);
        check("fill_overflow_sticky", int'(bus.overflow), 1);
        bus.ovf_clr = 1'b1;
        step();
        idle();
        check("ovf_clr", int'(bus.overflow), 0);

        // Full with simultaneous push and pop: push dropped, pop taken
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 8'hB0 + 8'(i), 1'b0);
            exp_q.push_back(8'hB0 + 8'(i));
            step();
        end
        drive(1'b1, 8'h55, 1'b1);
        step();
        idle();
        check("fullrw_level",    int'(bus.level),    7);
        check("fullrw_overflow", int'(bus.overflow), 1);
        check("fullrw_head",     int'(bus.rd_data),  8'hB1);
        check("fullrw_full",     int'(bus.full),     0);
        drive(1'b0, '0, 1'b1);
        repeat (DEPTH - 1) step();
        idle();
        check("fullrw_drained", int'(bus.empty), 1);
        bus.ovf_clr = 1'b1;
        step();
        idle();

        // Streaming 20 bytes with a pop every cycle after the first push
        drive(1'b1, 8'h00, 1'b0); exp_q.push_back(8'h00); step();
        for (int i = 1; i < 20; i++) begin
            drive(1'b1, 8'(i), 1'b1);
            exp_q.push_back(8'(i));
            step();
            check("pipe_level", int'(bus.level), 1);
        end
        drive(1'b0, '0, 1'b1);
        step();
        idle();
        check("pipe_empty",    int'(bus.empty),    1);
        check("pipe_overflow", int'(bus.overflow), 0);

        // Asynchronous reset mid-cycle with level 5
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'hC0 + 8'(i), 1'b0);
            step();
        end
        idle();
        check("pre_reset_level", int'(bus.level), 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_level", int'(bus.level), 0);
        check("async_rst_empty", int'(bus.empty), 1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        drive(1'b1, 8'h7E, 1'b0); exp_q.push_back(8'h7E); step();
        idle();
        check("post_rst_data",  int'(bus.rd_data), 8'h7E);
        check("post_rst_level", int'(bus.level),   1);

`ifdef SINK_PARITY_EN
        check("par_err_idle", int'(bus.par_err), 0);
        drive(1'b1, 8'h03, 1'b0);
        bus.data_par = 1'b1;
        step();
        idle();
        check("par_drop_level", int'(bus.level),   1);
        check("par_err_set",    int'(bus.par_err), 1);
        bus.ovf_clr = 1'b1;
        step();
        idle();
        check("par_err_clr", int'(bus.par_err), 0);
`endif

        drive(1'b0, '0, 1'b1);
        step();
        idle();
        check("final_empty",     int'(bus.empty), 1);
        check("scoreboard_left", exp_q.size(),    0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
